spi_burst_ctrl: RTL and testbench
=================================

SPI_BURST_CTRL -- requirements
Module: spi_burst_ctrl

Interface
REQ-001 Parameter MAX_BYTES_PER_CS, default 16: maximum bytes sent during one chip-select assertion.
REQ-002 Parameter CS_LEAD_CLKS, default 2: clk cycles from CS_n falling to the first master TX_DV pulse.
REQ-003 Parameter CS_INACTIVE_CLKS, default 4: minimum clk cycles CS_n stays high between bursts.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 i_TX_Count  input  $clog2(MAX_BYTES_PER_CS+1)  burst length, sampled with the first i_TX_DV of a burst.
REQ-007 i_TX_Byte  input  8  byte to send.
REQ-008 i_TX_DV  input  1  single-cycle request, accepted only when o_TX_Ready=1.
REQ-009 o_TX_Ready  output  1  controller can accept i_TX_DV this cycle.
REQ-010 o_M_TX_Byte  output  8  byte to the SPI master core.
REQ-011 o_M_TX_DV  output  1  one-cycle pulse to the SPI master core.
REQ-012 i_M_TX_Ready  input  1  SPI master core is idle.
REQ-013 i_M_RX_DV / i_M_RX_Byte  input  1 / 8  received byte from the SPI master core.
REQ-014 o_RX_DV / o_RX_Byte  output  1 / 8  received byte forwarded upstream.
REQ-015 o_RX_Count  output  same width as i_TX_Count  0-based index of o_RX_Byte within the burst.
REQ-016 o_SPI_CS_n  output  1  active-low chip select.

Function
REQ-017 FSM states SHALL be IDLE, LEAD, XFER and INACTIVE.
REQ-018 IDLE: o_TX_Ready=1, o_SPI_CS_n=1; i_TX_DV with i_TX_Count=0 SHALL be ignored.
REQ-019 IDLE with i_TX_DV and count!=0: latch byte; latch count, clamping values >MAX_BYTES_PER_CS to MAX_BYTES_PER_CS; move to LEAD; o_SPI_CS_n=0 and o_TX_Ready=0 from the next cycle.
REQ-020 LEAD SHALL last exactly CS_LEAD_CLKS cycles, then pulse o_M_TX_DV for one cycle with the latched byte, set bytes_left=count-1, and enter XFER.
REQ-021 In XFER, o_TX_Ready SHALL be combinational: i_M_TX_Ready & (bytes_left>0) & !o_M_TX_DV & !tx_pending, where tx_pending is set by an o_M_TX_DV pulse and cleared when i_M_TX_Ready falls.
REQ-022 An accepted i_TX_DV in XFER SHALL produce o_M_TX_DV one cycle later with that byte and SHALL decrement bytes_left.
REQ-023 i_TX_DV while o_TX_Ready=0 SHALL have no effect (byte dropped, no counter change).
REQ-024 Each i_M_RX_DV in LEAD or XFER SHALL produce o_RX_DV one cycle later, carrying the byte and the current rx index; the rx index SHALL then increment.
REQ-025 i_M_RX_DV in IDLE or INACTIVE SHALL be ignored.
REQ-026 XFER->INACTIVE SHALL occur on the cycle when bytes_left=0 and the rx index equals the latched count; o_SPI_CS_n SHALL rise the following cycle.
REQ-027 INACTIVE SHALL hold o_SPI_CS_n=1 and o_TX_Ready=0 for exactly CS_INACTIVE_CLKS cycles, then return to IDLE with the rx index cleared.
REQ-028 o_SPI_CS_n SHALL be glitch-free, driven from a flop; o_M_TX_DV and o_RX_DV SHALL never be high for two consecutive cycles.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, o_SPI_CS_n=1, o_M_TX_DV=0, o_RX_DV=0, o_RX_Byte=0, o_M_TX_Byte=0, o_RX_Count=0, and all counters 0.
REQ-030 o_TX_Ready SHALL be 1 after reset release; reset mid-burst SHALL abort the burst without emitting further pulses.

Verification
REQ-031 Count=1, byte 0xA5, master loopback -> CS_n low 2 cycles before the M_TX_DV pulse carrying 0xA5; one o_RX_DV with o_RX_Count=0; CS_n high for >=4 cycles before o_TX_Ready=1.
REQ-032 Count=3 with bytes 0x11, 0x22, 0x33 sent back-to-back as soon as ready -> three M_TX_DV pulses in order; o_RX_Count 0,1,2; CS_n stays low continuously.
REQ-033 i_TX_DV while o_TX_Ready=0 mid-burst -> no extra M_TX_DV pulse and no counter change.
REQ-034 i_TX_Count=0 in IDLE -> CS_n stays 1 and no M_TX_DV pulse; i_TX_Count=20 -> clamped so exactly 16 bytes are accepted.
REQ-035 rst_n asserted during byte 2 of 4 -> CS_n=1 and outputs at reset values in the same cycle; after release a new count=1 burst completes normally.
REQ-036 Stray i_M_RX_DV in IDLE -> no o_RX_DV pulse.

Source files
------------

// File: rtl/spi_burst_ctrl_if.sv
// Handshake bundle between the upstream requester, spi_burst_ctrl and the SPI master core.
// The slave modport is the controller's view; the master modport is the view of everything around it.
interface spi_burst_ctrl_if #(
    parameter int MAX_BYTES_PER_CS = 16
);
    localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);

    logic [CW-1:0] i_TX_Count;
    logic [7:0]    i_TX_Byte;
    logic          i_TX_DV;
    logic          o_TX_Ready;
    logic [7:0]    o_M_TX_Byte;
    logic          o_M_TX_DV;
    logic          i_M_TX_Ready;
    logic          i_M_RX_DV;
    logic [7:0]    i_M_RX_Byte;
    logic          o_RX_DV;
    logic [7:0]    o_RX_Byte;
    logic [CW-1:0] o_RX_Count;
    logic          o_SPI_CS_n;

    modport slave (
        input  i_TX_Count, i_TX_Byte, i_TX_DV, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
        output o_TX_Ready, o_M_TX_Byte, o_M_TX_DV, o_RX_DV, o_RX_Byte, o_RX_Count, o_SPI_CS_n
    );

    modport master (
        output i_TX_Count, i_TX_Byte, i_TX_DV, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
        input  o_TX_Ready, o_M_TX_Byte, o_M_TX_DV, o_RX_DV, o_RX_Byte, o_RX_Count, o_SPI_CS_n
    );
endinterface

// File: rtl/spi_burst_ctrl.sv
// Wraps an SPI master core so that a multi-byte burst is sent under a single chip-select
// assertion, with fixed lead time before the first byte and a minimum idle gap afterwards.
module spi_burst_ctrl #(
    parameter int MAX_BYTES_PER_CS = 16,
    parameter int CS_LEAD_CLKS     = 2,
    parameter int CS_INACTIVE_CLKS = 4
) (
    input logic             clk,
    input logic             rst_n,
    spi_burst_ctrl_if.slave bus
);
    localparam int CW   = $clog2(MAX_BYTES_PER_CS + 1);
    localparam int TMAX = (CS_LEAD_CLKS > CS_INACTIVE_CLKS) ? CS_LEAD_CLKS : CS_INACTIVE_CLKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_BYTES_PER_CS);
    localparam logic [TW-1:0] LEAD_LAST  = TW'(CS_LEAD_CLKS - 1);
    localparam logic [TW-1:0] INACT_LAST = TW'(CS_INACTIVE_CLKS - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, INACTIVE} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [TW-1:0] r_timer;
    logic [CW-1:0] r_count;
    logic [7:0]    r_byte;
    logic [CW-1:0] r_bytes_left;
    logic [CW-1:0] r_rx_idx;
    logic          r_tx_pending;
    logic          r_m_tx_dv;
    logic [7:0]    r_m_tx_byte;
    logic          r_rx_dv;
    logic [7:0]    r_rx_byte;
    logic [CW-1:0] r_rx_count;
    logic          r_cs_n;

    logic          w_tx_ready;
    logic          w_lead_done;
    logic          w_xfer_done;
    logic          w_inact_done;
    logic          w_accept;
    logic          w_start;
    logic          w_xfer_tx;
    logic          w_rx_take;
    logic [CW-1:0] w_clamped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_tx_ready   = 1'b0;
        w_lead_done  = 1'b0;
        w_xfer_done  = 1'b0;
        w_inact_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_ready = 1'b1;
                if (bus.i_TX_DV && (bus.i_TX_Count != '0)) begin
                    w_next_state = LEAD;
                end
            end
            LEAD: begin
                w_lead_done = (r_timer == LEAD_LAST);
                if (w_lead_done) begin
                    w_next_state = XFER;
                end
            end
            XFER: begin
                // Hold off new bytes until the master core has visibly taken the previous one.
                w_tx_ready  = bus.i_M_TX_Ready && (r_bytes_left != '0) && !r_m_tx_dv && !r_tx_pending;
                w_xfer_done = (r_bytes_left == '0) && (r_rx_idx == r_count);
                if (w_xfer_done) begin
                    w_next_state = INACTIVE;
                end
            end
            INACTIVE: begin
                w_inact_done = (r_timer == INACT_LAST);
                if (w_inact_done) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_accept  = bus.i_TX_DV && w_tx_ready;
    assign w_start   = (r_state == IDLE) && w_accept && (bus.i_TX_Count != '0);
    assign w_xfer_tx = (r_state == XFER) && w_accept;
    assign w_rx_take = bus.i_M_RX_DV && ((r_state == LEAD) || (r_state == XFER));
    assign w_clamped = (bus.i_TX_Count > MAX_CNT) ? MAX_CNT : bus.i_TX_Count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer      <= '0;
            r_count      <= '0;
            r_byte       <= '0;
            r_bytes_left <= '0;
            r_rx_idx     <= '0;
            r_tx_pending <= 1'b0;
            r_m_tx_dv    <= 1'b0;
            r_m_tx_byte  <= '0;
            r_rx_dv      <= 1'b0;
            r_rx_byte    <= '0;
            r_rx_count   <= '0;
            r_cs_n       <= 1'b1;
        end else begin
            if (w_next_state != r_state) begin
                r_timer <= '0;
            end else if ((r_state == LEAD) || (r_state == INACTIVE)) begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_start) begin
                r_count <= w_clamped;
                r_byte  <= bus.i_TX_Byte;
            end

            r_m_tx_dv <= w_lead_done || w_xfer_tx;
            if (w_lead_done) begin
                r_m_tx_byte  <= r_byte;
                r_bytes_left <= r_count - 1'b1;
            end else if (w_xfer_tx) begin
                r_m_tx_byte  <= bus.i_TX_Byte;
                r_bytes_left <= r_bytes_left - 1'b1;
            end

            if (r_m_tx_dv) begin
                r_tx_pending <= 1'b1;
            end else if (!bus.i_M_TX_Ready || (r_state == IDLE)) begin
                r_tx_pending <= 1'b0;
            end

            r_rx_dv <= w_rx_take;
            if (w_inact_done) begin
                r_rx_idx <= '0;
            end else if (w_rx_take) begin
                r_rx_byte  <= bus.i_M_RX_Byte;
                r_rx_count <= r_rx_idx;
                r_rx_idx   <= r_rx_idx + 1'b1;
            end

            if (w_start) begin
                r_cs_n <= 1'b0;
            end else if (w_xfer_done) begin
                r_cs_n <= 1'b1;
            end
        end
    end

    assign bus.o_TX_Ready  = w_tx_ready;
    assign bus.o_M_TX_DV   = r_m_tx_dv;
    assign bus.o_M_TX_Byte = r_m_tx_byte;
    assign bus.o_RX_DV     = r_rx_dv;
    assign bus.o_RX_Byte   = r_rx_byte;
    assign bus.o_RX_Count  = r_rx_count;
    assign bus.o_SPI_CS_n  = r_cs_n;
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Randomized bench for spi_burst_ctrl: a loopback SPI master model, an upstream driver that
// queues expected bytes as they are accepted, and a monitor that checks every DUT pulse.
module tb_spi_burst_ctrl;
    localparam int MAXB   = 16;
    localparam int LEAD   = 2;
    localparam int INACT  = 4;
    localparam int CW     = $clog2(MAXB + 1);

    logic clk;
    logic rst_n;

    spi_burst_ctrl_if #(.MAX_BYTES_PER_CS(MAXB)) bus ();

    spi_burst_ctrl #(
        .MAX_BYTES_PER_CS(MAXB),
        .CS_LEAD_CLKS    (LEAD),
        .CS_INACTIVE_CLKS(INACT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int nVectors     = 0;
    int nMiscompares = 0;

    logic [7:0]    txQ[$];
    logic [7:0]    rxByteQ[$];
    logic [CW-1:0] rxIdxQ[$];
    logic [7:0]    byteFeed[$];

    bit         expectBurst = 1'b0;
    bit         strayReq    = 1'b0;
    logic [7:0] strayByte   = 8'h00;
    int         txSeen      = 0;
    int         rxSeen      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name, input logic [31:0] actual);
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL %s: actual pulse with value 0x%0h, required no pulse", name, actual);
    endtask

    // Loopback master core: busy for a few cycles after each byte, then returns the same byte.
    initial begin : masterModel
        bit         busy;
        int         delay;
        logic [7:0] shiftByte;
        busy      = 1'b0;
        delay     = 0;
        shiftByte = 8'h00;
        bus.i_M_TX_Ready = 1'b1;
        bus.i_M_RX_DV    = 1'b0;
        bus.i_M_RX_Byte  = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            bus.i_M_RX_DV = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
                bus.i_M_TX_Ready = 1'b1;
            end else if (strayReq) begin
                bus.i_M_RX_DV   = 1'b1;
                bus.i_M_RX_Byte = strayByte;
                strayReq        = 1'b0;
            end else if (busy) begin
                if (delay == 0) begin
                    bus.i_M_RX_DV    = 1'b1;
                    bus.i_M_RX_Byte  = shiftByte;
                    bus.i_M_TX_Ready = 1'b1;
                    busy             = 1'b0;
                end else begin
                    delay--;
                end
            end else if (bus.o_M_TX_DV) begin
                shiftByte        = bus.o_M_TX_Byte;
                busy             = 1'b1;
                delay            = int'($urandom_range(2, 6));
                bus.i_M_TX_Ready = 1'b0;
            end
        end
    end

    bit csPrev       = 1'b1;
    bit txPrev       = 1'b0;
    bit rxPrev       = 1'b0;
    bit leadPending  = 1'b0;
    bit inactPending = 1'b0;
    int cycle        = 0;
    int csFallCycle  = 0;
    int csRiseCycle  = 0;
    int lastRxCycle  = 0;

    // Monitor: pops the scoreboard on every DUT pulse and times the chip-select edges.
    initial begin : monitor
        logic [7:0]    expByte;
        logic [CW-1:0] expIdx;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (!rst_n) begin
                csPrev       = 1'b1;
                txPrev       = 1'b0;
                rxPrev       = 1'b0;
                leadPending  = 1'b0;
                inactPending = 1'b0;
            end else begin
                if (csPrev && !bus.o_SPI_CS_n) begin
                    checkOutput("cs_fall_requested", 32'(expectBurst), 32'd1);
                    expectBurst = 1'b0;
                    csFallCycle = cycle;
                    leadPending = 1'b1;
                end
                if (!csPrev && bus.o_SPI_CS_n) begin
                    checkOutput("burst_drained_at_cs_rise", 32'(txQ.size() + rxByteQ.size()), 32'd0);
                    checkOutput("cs_rise_after_last_rx", 32'(cycle - lastRxCycle), 32'd1);
                    csRiseCycle  = cycle;
                    inactPending = 1'b1;
                end
                if (inactPending && bus.o_TX_Ready) begin
                    checkOutput("cs_inactive_clks", 32'(cycle - csRiseCycle), 32'(INACT));
                    inactPending = 1'b0;
                end
                if (bus.o_M_TX_DV) begin
                    txSeen++;
                    checkOutput("m_tx_dv_single_cycle", 32'(txPrev), 32'd0);
                    if (leadPending) begin
                        checkOutput("cs_lead_clks", 32'(cycle - csFallCycle), 32'(LEAD));
                        leadPending = 1'b0;
                    end
                    if (txQ.size() == 0) begin
                        reportUnexpected("m_tx_unexpected", 32'(bus.o_M_TX_Byte));
                    end else begin
                        expByte = txQ.pop_front();
                        checkOutput("m_tx_byte", 32'(bus.o_M_TX_Byte), 32'(expByte));
                    end
                end
                if (bus.o_RX_DV) begin
                    rxSeen++;
                    lastRxCycle = cycle;
                    checkOutput("rx_dv_single_cycle", 32'(rxPrev), 32'd0);
                    checkOutput("cs_low_during_rx", 32'(bus.o_SPI_CS_n), 32'd0);
                    if (rxByteQ.size() == 0) begin
                        reportUnexpected("rx_unexpected", 32'(bus.o_RX_Byte));
                    end else begin
                        expByte = rxByteQ.pop_front();
                        expIdx  = rxIdxQ.pop_front();
                        checkOutput("rx_byte", 32'(bus.o_RX_Byte), 32'(expByte));
                        checkOutput("rx_count", 32'(bus.o_RX_Count), 32'(expIdx));
                    end
                end
                csPrev = bus.o_SPI_CS_n;
                txPrev = bus.o_M_TX_DV;
                rxPrev = bus.o_RX_DV;
            end
        end
    end

    // Offers one byte as soon as the DUT is ready and records what the model expects back.
    task automatic sendWhenReady(input logic [7:0] b, input logic [CW-1:0] cnt, input int idx, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.o_TX_Ready) begin
                txQ.push_back(b);
                rxByteQ.push_back(b);
                rxIdxQ.push_back(CW'(idx));
                bus.i_TX_DV    = 1'b1;
                bus.i_TX_Byte  = b;
                bus.i_TX_Count = cnt;
                ok             = 1'b1;
                @(negedge clk);
                bus.i_TX_DV = 1'b0;
                break;
            end
        end
        if (!ok) begin
            checkOutput("tx_ready_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic applyStimulus(input int reqCount, input bit injectJunk);
        int         eff;
        bit         ok;
        bit         extraReady;
        logic [7:0] b;
        logic [CW-1:0] cnt;
        int         txBefore;
        eff        = (reqCount > MAXB) ? MAXB : reqCount;
        cnt        = CW'(reqCount);
        extraReady = 1'b0;
        if (reqCount == 0) begin
            txBefore = txSeen;
            @(negedge clk);
            bus.i_TX_DV    = 1'b1;
            bus.i_TX_Count = '0;
            bus.i_TX_Byte  = 8'($urandom);
            @(negedge clk);
            bus.i_TX_DV = 1'b0;
            repeat (8) @(negedge clk);
            checkOutput("count0_cs_high", 32'(bus.o_SPI_CS_n), 32'd1);
            checkOutput("count0_no_m_tx", 32'(txSeen - txBefore), 32'd0);
            return;
        end
        for (int i = 0; i < eff; i++) begin
            b = (byteFeed.size() != 0) ? byteFeed.pop_front() : 8'($urandom);
            if (i == 0) begin
                expectBurst = 1'b1;
            end
            if (injectJunk && (i == 1)) begin
                @(negedge clk);
                if (!bus.o_TX_Ready) begin
                    bus.i_TX_DV   = 1'b1;
                    bus.i_TX_Byte = 8'hEE;
                end
                @(negedge clk);
                bus.i_TX_DV = 1'b0;
            end
            sendWhenReady(b, cnt, i, ok);
            if (!ok) begin
                return;
            end
        end
        ok = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (!bus.o_SPI_CS_n && bus.o_TX_Ready) begin
                extraReady = 1'b1;
            end
            if (bus.o_SPI_CS_n && bus.o_TX_Ready) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("burst_returned_idle", 32'(ok), 32'd1);
        checkOutput("no_ready_after_last_byte", 32'(extraReady), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cs_n"},      32'(bus.o_SPI_CS_n),  32'd1);
        checkOutput({tag, "_m_tx_dv"},   32'(bus.o_M_TX_DV),   32'd0);
        checkOutput({tag, "_rx_dv"},     32'(bus.o_RX_DV),     32'd0);
        checkOutput({tag, "_rx_byte"},   32'(bus.o_RX_Byte),   32'd0);
        checkOutput({tag, "_m_tx_byte"}, 32'(bus.o_M_TX_Byte), 32'd0);
        checkOutput({tag, "_rx_count"},  32'(bus.o_RX_Count),  32'd0);
    endtask

    initial begin : stimulus
        int rxBefore;
        int n;
        bit ok;
        rst_n          = 1'b0;
        bus.i_TX_DV    = 1'b0;
        bus.i_TX_Byte  = 8'h00;
        bus.i_TX_Count = '0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(bus.o_TX_Ready), 32'd1);

        byteFeed.push_back(8'hA5);
        applyStimulus(1, 1'b0);

        byteFeed.push_back(8'h11);
        byteFeed.push_back(8'h22);
        byteFeed.push_back(8'h33);
        applyStimulus(3, 1'b0);

        applyStimulus(0, 1'b0);

        rxBefore  = rxSeen;
        strayByte = 8'h3C;
        strayReq  = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("stray_rx_ignored", 32'(rxSeen - rxBefore), 32'd0);

        applyStimulus(5, 1'b1);
        applyStimulus(20, 1'b0);

        for (int k = 0; k < 10; k++) begin
            n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(1, 16));
            applyStimulus(n, 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset during byte 2 of a 4-byte burst");
        expectBurst = 1'b1;
        sendWhenReady(8'h5A, CW'(4), 0, ok);
        sendWhenReady(8'hC3, CW'(4), 1, ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetValues("midburst_reset");
        txQ.delete();
        rxByteQ.delete();
        rxIdxQ.delete();
        expectBurst = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_midburst_reset", 32'(bus.o_TX_Ready), 32'd1);
        checkOutput("cs_high_after_midburst_reset", 32'(bus.o_SPI_CS_n), 32'd1);
        applyStimulus(1, 1'b0);

        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
